dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 The module SHALL have parameter LATENCY, default 3, meaning cycles from request acceptance to response (legal range 1..15).
REQ-003 The module SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning the byte address of word 0.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port addr  input  32  the byte address from the pipeline memory stage.
REQ-007 The module SHALL have port data_in  input  32  the store data.
REQ-008 The module SHALL have port mem_read  input  1  the load request.
REQ-009 The module SHALL have port mem_write  input  1  the store request.
REQ-010 The module SHALL have port data_out  output  32  the load data, valid only in state DONE.
REQ-011 The module SHALL have port stall  output  1  high to freeze the requesting pipeline.
REQ-012 The module SHALL have port err  output  1  a one-cycle pulse on a rejected request.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-014 In IDLE, a valid request (exactly one of mem_read/mem_write, addr[1:0]==0, word index (addr-BASE_ADDR)>>2 < DEPTH_WORDS) SHALL latch addr, data_in and the operation, load the counter with LATENCY-1, and go to WAIT; when LATENCY==1 it SHALL go directly to DONE.
REQ-015 stall SHALL be combinational: high in IDLE when a valid request is present, high throughout WAIT, and low in DONE.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and on the cycle it is 1 the FSM SHALL move to DONE.
REQ-017 The total stall length SHALL be exactly LATENCY cycles per accepted request.
REQ-018 A store SHALL commit to storage on the edge entering DONE, using the latched address and data.
REQ-019 A load SHALL drive data_out from the latched word index during DONE, and data_out SHALL be 0 in all other states.
REQ-020 A load in DONE SHALL observe any store committed by an earlier request (read-after-write is ordered).
REQ-021 DONE SHALL last one cycle and return to IDLE; requests present in DONE SHALL be ignored (the pipeline advances at that edge).
REQ-022 Input changes during WAIT SHALL be ignored because the latched values govern the access.
REQ-023 An invalid request in IDLE (misaligned, out of range, or both enables high) SHALL pulse err for one cycle, perform no access, keep stall low, and leave the FSM in IDLE.
REQ-024 No request in IDLE SHALL mean stall=0, err=0 and no state change.

Reset
REQ-025 On reset low, the state SHALL asynchronously go to IDLE, the counter to 0, data_out, stall and err to 0, and the latched request registers to 0.
REQ-026 Reset asserted mid-WAIT SHALL abort the access, and a pending store SHALL NOT commit.
REQ-027 Storage contents SHALL NOT be affected by reset.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum typedef, the default LATENCY, DEPTH_WORDS and BASE_ADDR constants, and the word-index width function.
REQ-029 The countdown SHALL be one sub-module, latency_counter (load, decrement, is_one flag), with everything else in dmem_responder.

Verification
REQ-030 Store then load: write 0xDEADBEEF @0x1000_0008, LATENCY=3 -> stall high 3 cycles, then DONE; the load of 0x1000_0008 -> data_out 0xDEADBEEF in DONE after 3 stall cycles.
REQ-031 Misaligned: mem_read @0x1000_0002 -> err=1 for 1 cycle, stall=0, FSM remains IDLE.
REQ-032 Out of range: mem_write @0x1000_0400 with DEPTH_WORDS=256 -> err pulse, and a later load of word 0 is unchanged.
REQ-033 Input churn: change addr/data_in every WAIT cycle -> the originally latched address and data are used.
REQ-034 Reset mid-WAIT: store 0x1234 @0x1000_0000, drop reset on the 2nd WAIT cycle -> IDLE, stall=0, and a later load returns the old value.
REQ-035 LATENCY=1: back-to-back loads -> stall high exactly 1 cycle each, with DONE on alternate cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DEF_DEPTH_WORDS = 256;
  localparam int unsigned DEF_LATENCY     = 3;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;

  // Countdown width: enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index `depth` words (at least 1).
  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter that flags the cycle on which it holds 1.
module latency_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (load_i)              cnt_q <= load_val_i;
    else if (dec_i && cnt_q != 0) cnt_q <= cnt_q - 1'b1;
  end

  assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the pipeline for LATENCY
// cycles per accepted access, rejects malformed requests with an err pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEF_LATENCY,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        err
);

  localparam int unsigned      IW       = idx_width(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   data_q;
  logic          is_write_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   widx;
  logic          req_any, req_ok, accept, cnt_one, commit;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_data;

  // Request qualification, stall, store-commit selection and load data.
  // Addresses below BASE_ADDR wrap to huge indices and fail the range check.
  always_comb begin
    widx    = (addr - BASE_ADDR) >> 2;
    req_any = mem_read | mem_write;
    req_ok  = (mem_read ^ mem_write) && (addr[1:0] == 2'b00) && (widx < DEPTH_WORDS);
    accept  = (state_q == IDLE) && req_ok;
    stall   = accept || (state_q == WAIT);
    // With LATENCY==1 DONE is entered straight from IDLE, before the
    // latches hold the request, so the store uses the live inputs.
    if (state_q == IDLE) begin
      commit  = (LATENCY == 1) && accept && mem_write;
      wr_idx  = widx[IW-1:0];
      wr_data = data_in;
    end else begin
      commit  = (state_q == WAIT) && cnt_one && is_write_q;
      wr_idx  = idx_q;
      wr_data = data_q;
    end
    data_out = ((state_q == DONE) && !is_write_q) ? mem_q[idx_q] : 32'h0;
  end

  assign err = err_q;

  // Control FSM plus latched request and registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && req_any && !req_ok;
      unique case (state_q)
        IDLE: if (accept) begin
          idx_q      <= widx[IW-1:0];
          data_q     <= data_in;
          is_write_q <= mem_write;
          state_q    <= (LATENCY == 1) ? DONE : WAIT;
        end
        WAIT:    if (cnt_one) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a store lands on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_idx] <= wr_data;
  end

  latency_counter #(.W(CNT_W)) u_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (accept),
    .load_val_i (CNT_LOAD),
    .dec_i      (state_q == WAIT),
    .is_one_o   (cnt_one)
  );

endmodule
